matrix_result_drain: RTL and testbench
======================================

Name: matrix_result_drain

Overview:
- Downstream stage of the systolic-array top.
- Captures the full N×N signed 32-bit result matrix on the single-cycle result-valid pulse.
- Streams the matrix out one row per beat on a valid/ready interface toward the writeback/DMA path.
- Reports idle so the issuing controller only launches a new multiply once the buffer is free.

Parameters:
N, 8, matrix dimension; must match the array; legal range 3..256.
W, 32, element width in bits; must match the array result width.
IW, $clog2(N), row index width (derived localparam, not overridable).

Ports:
i_clk  input  1  clock
i_arst  input  1  reset
i_c  input  [N-1:0][N-1:0][W-1:0] signed  result matrix from the array; i_c[r][c] is row r, column c
i_validResult  input  1  one-cycle pulse; i_c is stable and complete in this cycle
o_idle  output  1  high when the buffer is empty and a capture will not drop data
o_row  output  [N-1:0][W-1:0] signed  current row; o_row[c] = element (rowIdx, c)
o_rowIdx  output  IW  index of the row currently presented
o_valid  output  1  o_row is valid
i_ready  input  1  consumer accepts the beat when o_valid && i_ready
o_last  output  1  high with o_valid while o_rowIdx == N-1
o_overrun  output  1  sticky: a result pulse arrived while busy and was dropped
i_clearOverrun  input  1  synchronous clear of o_overrun

Behaviour:
- Reset: i_arst is asynchronous, active-high; clock is i_clk.
- Reset values: state IDLE, buffer all-zero, o_valid=0, o_rowIdx=0, o_last=0, o_overrun=0, o_idle=1.
- State IDLE:
  - o_valid=0, o_idle=1.
  - On i_validResult: register all of i_c into the buffer, set rowIdx=0, go to DRAIN.
  - o_valid rises the next cycle (capture-to-first-beat latency = 1 cycle).
- State DRAIN:
  - o_idle=0, o_valid=1.
  - o_row is driven from buffer[rowIdx]. It is a mux off registered state only, with no combinational path from i_ready or i_c.
- Transfer rule: a beat transfers on a rising edge with o_valid && i_ready.
  - On transfer with rowIdx < N-1: rowIdx increments.
  - On transfer with rowIdx == N-1: go to IDLE, rowIdx=0, o_valid=0 next cycle.
- Stall: with i_ready=0, o_row, o_rowIdx and o_last hold indefinitely.
- Simultaneous events:
  - i_validResult in the same cycle as the final-row transfer: capture the new matrix, rowIdx=0, stay in DRAIN. o_valid stays high with no bubble; the next beat is row 0 of the new matrix.
  - i_validResult in DRAIN at any other time: drop it, buffer unchanged, set o_overrun=1.
  - i_clearOverrun and a new overrun in the same cycle: set wins.
  - i_validResult while in IDLE is always captured.
- Width rules:
  - Elements are copied verbatim; no arithmetic unless the optional feature is enabled.
  - The comparison rowIdx == N-1 uses IW bits.
- Reset mid-drain: abort immediately, clear the buffer, return to the reset values. No partial beats follow.
- Throughput: one row per cycle with i_ready held high. A full drain takes N cycles, which is shorter than the array's 3N+ cycle compute time, so back-to-back multiplies never overrun under full ready.

Optional Feature:
RESULT_DRAIN_RELU_EN
- Defined: at capture, each element with sign bit set is stored as 0, and non-negative elements are stored unchanged. Latency and handshake are unaffected.
- Undefined: elements are stored verbatim, including negative values.

Test Plan:
- Basic drain:
  - Stimulus: N=4; i_c[r][c]=16*r+c (row 2 = 32,33,34,35); pulse i_validResult; i_ready=1.
  - Response: o_valid rises 1 cycle later; 4 consecutive beats with rowIdx 0..3; row 2 = {32,33,34,35}; o_last only on beat 3; o_idle=1 the cycle after the last beat.
- Back-pressure:
  - Stimulus: same matrix; i_ready=0 for 5 cycles at row 1, then i_ready=1.
  - Response: o_row={16,17,18,19} and rowIdx=1 held for all 5 cycles; no beat is skipped or duplicated.
- Overrun:
  - Stimulus: second pulse while presenting row 1.
  - Response: o_overrun=1; beats 2..3 still carry the first matrix; o_overrun stays 1 until i_clearOverrun, then reads 0.
- Seamless restart:
  - Stimulus: second matrix (all elements 7) pulsed in the same cycle as the row-3 transfer.
  - Response: o_valid never drops; the next beat is rowIdx=0 with all elements 7; o_overrun stays 0.
- Reset mid-drain:
  - Stimulus: assert i_arst asynchronously during row 2.
  - Response: o_valid, o_rowIdx and o_last read 0 immediately; o_idle=1; after release, no beats appear until a new pulse.
- Negative values:
  - Stimulus: i_c[0][0]=-5 (32'hFFFFFFFB), i_c[0][1]=9.
  - Response: without RESULT_DRAIN_RELU_EN, row 0 = {-5, 9, ...}; with it defined, row 0 = {0, 9, ...}.

Source files
------------

// File: rtl/matrix_result_drain_if.sv
// Row stream from the result drain toward writeback/DMA.
// One row of N signed W-bit elements per beat, valid/ready handshake.
interface matrix_result_drain_if #(
   parameter int N = 8,
   parameter int W = 32
);
   localparam int IW = $clog2(N);

   logic signed [N-1:0][W-1:0] o_row;
   logic        [IW-1:0]       o_rowIdx;
   logic                       o_valid;
   logic                       o_last;
   logic                       i_ready;

   modport master (
      output o_row,
      output o_rowIdx,
      output o_valid,
      output o_last,
      input  i_ready
   );

   modport slave (
      input  o_row,
      input  o_rowIdx,
      input  o_valid,
      input  o_last,
      output i_ready
   );
endinterface

// File: rtl/matrix_result_drain.sv
// Captures the N x N systolic result on its valid pulse and drains it row by row.
// Optional RESULT_DRAIN_RELU_EN clamps negative elements to zero at capture.
module matrix_result_drain #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic                             i_clk,
   input  logic                             i_arst,
   input  logic signed [N-1:0][N-1:0][W-1:0] i_c,
   input  logic                             i_validResult,
   output logic                             o_idle,
   output logic                             o_overrun,
   input  logic                             i_clearOverrun,
   matrix_result_drain_if.master            rd
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   if (N < 3 || N > 256) begin : g_bad_n
      $error("matrix_result_drain: N out of range");
   end

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t state_q, state_d;
   logic [IW-1:0] row_q, row_d;
   logic ovr_q, ovr_d;
   logic [N-1:0][N-1:0][W-1:0] buf_q;
   logic [N-1:0][N-1:0][W-1:0] cap_c;
   logic capture;
   logic drop;
   logic xfer;
   logic at_last;

   assign xfer    = (state_q == DRAIN) && rd.i_ready;
   assign at_last = (row_q == LAST_IDX);

   always_comb begin
      cap_c = i_c;
`ifdef RESULT_DRAIN_RELU_EN
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (i_c[r][c][W-1]) cap_c[r][c] = '0;
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      capture = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_validResult) begin
               capture = 1'b1;
               row_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer) begin
               if (at_last) begin
                  row_d   = '0;
                  state_d = IDLE;
               end else begin
                  row_d = row_q + IW'(1);
               end
            end
            // A new result only fits when the final row leaves this cycle
            if (i_validResult) begin
               if (xfer && at_last) begin
                  capture = 1'b1;
                  row_d   = '0;
                  state_d = DRAIN;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            row_d   = '0;
         end
      endcase
      ovr_d = drop | (ovr_q & ~i_clearOverrun);
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= IDLE;
         row_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         ovr_q   <= ovr_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         buf_q <= '0;
      end else if (capture) begin
         buf_q <= cap_c;
      end
   end

   assign rd.o_valid  = (state_q == DRAIN);
   assign rd.o_rowIdx = row_q;
   assign rd.o_row    = buf_q[row_q];
   assign rd.o_last   = (state_q == DRAIN) && at_last;
   assign o_idle      = (state_q == IDLE);
   assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain at N=4 with a row-queue reference model.
// Literal checks pin the model at key points of each scenario.
module tb_matrix_result_drain;
   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   logic arst = 1'b1;
   logic vr;
   logic clr;
   logic idle;
   logic ovr;
   logic signed [N-1:0][N-1:0][W-1:0] c;

   int n_checks = 0;
   int n_fail = 0;

   matrix_result_drain_if #(.N(N), .W(W)) rd ();

   matrix_result_drain #(.N(N), .W(W)) dut (
      .i_clk          (clk),
      .i_arst         (arst),
      .i_c            (c),
      .i_validResult  (vr),
      .o_idle         (idle),
      .o_overrun      (ovr),
      .i_clearOverrun (clr),
      .rd             (rd.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                   idx;
      logic [N-1:0][W-1:0]  row;
   } beat_t;

   beat_t q[$];
   logic  m_ovr = 1'b0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef RESULT_DRAIN_RELU_EN
      return v[W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Model: queue of rows still owed to the consumer; front is on the bus.
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         q.delete();
         m_ovr = 1'b0;
      end else begin
         if (q.size() != 0 && rd.i_ready) void'(q.pop_front());
         if (clr) m_ovr = 1'b0;
         if (vr) begin
            if (q.size() == 0) begin
               for (int r = 0; r < N; r++) begin
                  beat_t b;
                  b.idx = r;
                  for (int k = 0; k < N; k++) b.row[k] = relu(c[r][k]);
                  q.push_back(b);
               end
            end else begin
               m_ovr = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("m_valid", 128'(rd.o_valid), 128'(q.size() != 0));
      chk("m_idle", 128'(idle), 128'(q.size() == 0));
      chk("m_overrun", 128'(ovr), 128'(m_ovr));
      if (q.size() != 0) begin
         chk("m_rowidx", 128'(rd.o_rowIdx), 128'(q[0].idx));
         chk("m_last", 128'(rd.o_last), 128'(q[0].idx == N - 1));
         chk("m_row", 128'(rd.o_row), 128'(q[0].row));
      end else begin
         chk("m_last_idle", 128'(rd.o_last), 128'(0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_a();
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) c[r][k] = 32'(16 * r + k);
   endtask

   task automatic fill_const(input logic [W-1:0] v);
      for (int r = 0; r < N; r++)
         for (int k = 0; k < N; k++) c[r][k] = v;
   endtask

   logic [W-1:0] exp_neg5;
   logic [W-1:0] exp_neg1;

   initial begin
      vr = 1'b0;
      clr = 1'b0;
      rd.i_ready = 1'b0;
      c = '0;

      @(negedge clk);
      chk("rst_idle", 128'(idle), 128'(1));
      chk("rst_valid", 128'(rd.o_valid), 128'(0));
      chk("rst_rowidx", 128'(rd.o_rowIdx), 128'(0));
      chk("rst_overrun", 128'(ovr), 128'(0));
      @(posedge clk);
      #1 arst = 1'b0;

      // basic drain
      fill_a();
      vr = 1'b1;
      rd.i_ready = 1'b1;
      tick();
      vr = 1'b0;
      @(negedge clk);
      chk("b_valid0", 128'(rd.o_valid), 128'(1));
      chk("b_idx0", 128'(rd.o_rowIdx), 128'(0));
      @(negedge clk);
      chk("b_idx1", 128'(rd.o_rowIdx), 128'(1));
      chk("b_last1", 128'(rd.o_last), 128'(0));
      @(negedge clk);
      chk("b_idx2", 128'(rd.o_rowIdx), 128'(2));
      chk("b_row2", 128'(rd.o_row), {32'd35, 32'd34, 32'd33, 32'd32});
      @(negedge clk);
      chk("b_idx3", 128'(rd.o_rowIdx), 128'(3));
      chk("b_last3", 128'(rd.o_last), 128'(1));
      @(negedge clk);
      chk("b_idle_after", 128'(idle), 128'(1));
      chk("b_valid_after", 128'(rd.o_valid), 128'(0));

      // back-pressure at row 1
      tick();
      vr = 1'b1;
      tick();
      vr = 1'b0;
      tick();
      rd.i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_idx", 128'(rd.o_rowIdx), 128'(1));
         chk("bp_row", 128'(rd.o_row), {32'd19, 32'd18, 32'd17, 32'd16});
      end
      rd.i_ready = 1'b1;
      repeat (4) tick();

      // overrun while on row 1; clear in the same cycle loses to set
      vr = 1'b1;
      tick();
      vr = 1'b0;
      tick();
      fill_const(32'd99);
      vr = 1'b1;
      clr = 1'b1;
      tick();
      vr = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      chk("ov_set_wins", 128'(ovr), 128'(1));
      chk("ov_idx2", 128'(rd.o_rowIdx), 128'(2));
      chk("ov_row2", 128'(rd.o_row), {32'd35, 32'd34, 32'd33, 32'd32});
      tick();
      @(negedge clk);
      chk("ov_row3", 128'(rd.o_row), {32'd51, 32'd50, 32'd49, 32'd48});
      repeat (3) tick();
      @(negedge clk);
      chk("ov_sticky", 128'(ovr), 128'(1));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("ov_cleared", 128'(ovr), 128'(0));

      // seamless restart on the final-row transfer
      fill_a();
      vr = 1'b1;
      tick();
      vr = 1'b0;
      repeat (3) tick();
      fill_const(32'd7);
      vr = 1'b1;
      tick();
      vr = 1'b0;
      @(negedge clk);
      chk("sr_valid", 128'(rd.o_valid), 128'(1));
      chk("sr_idx0", 128'(rd.o_rowIdx), 128'(0));
      chk("sr_row0", 128'(rd.o_row), {32'd7, 32'd7, 32'd7, 32'd7});
      chk("sr_no_ovr", 128'(ovr), 128'(0));
      repeat (5) tick();

      // asynchronous reset during row 2
      fill_a();
      vr = 1'b1;
      tick();
      vr = 1'b0;
      repeat (2) tick();
      #2 arst = 1'b1;
      #1;
      chk("ar_valid", 128'(rd.o_valid), 128'(0));
      chk("ar_idx", 128'(rd.o_rowIdx), 128'(0));
      chk("ar_last", 128'(rd.o_last), 128'(0));
      chk("ar_idle", 128'(idle), 128'(1));
      @(posedge clk);
      #1 arst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ar_no_beat", 128'(rd.o_valid), 128'(0));
      end

      // negative elements
`ifdef RESULT_DRAIN_RELU_EN
      exp_neg5 = 32'h0;
      exp_neg1 = 32'h0;
`else
      exp_neg5 = 32'hFFFF_FFFB;
      exp_neg1 = 32'hFFFF_FFFF;
`endif
      c = '0;
      c[0][0] = 32'hFFFF_FFFB;
      c[0][1] = 32'd9;
      c[1][2] = 32'hFFFF_FFFF;
      vr = 1'b1;
      tick();
      vr = 1'b0;
      @(negedge clk);
      chk("neg_e00", 128'(rd.o_row[0]), 128'(exp_neg5));
      chk("neg_e01", 128'(rd.o_row[1]), 128'(32'd9));
      @(negedge clk);
      chk("neg_e12", 128'(rd.o_row[2]), 128'(exp_neg1));
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
